// File: rtl/sopc_pio_wdata_if.sv
// ---------------------------------------------------------------------------
// sopc_pio_wdata_if
//
// Avalon-MM slave bus bundle for the output PIO.
//   address    : word address (3 bits)
//   chipselect : slave select
//   write_n    : active-low write strobe
//   writedata  : 32-bit write data
//   readdata   : 32-bit registered read data (driven by the slave)
// The master modport is the CPU side; the slave modport is the PIO side.
// ---------------------------------------------------------------------------
interface sopc_pio_wdata_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/sopc_pio_wdata.sv
// ---------------------------------------------------------------------------
// sopc_pio_wdata
//
// Avalon-MM output PIO driving an 8-bit out_port. The CPU writes a data
// register directly or through atomic SET / CLEAR registers, and can launch
// a self-timed inversion pulse of pulse_len cycles on a chosen bit mask.
//
// Ports:
//   clk      : system clock, all registers on the rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : Avalon-MM slave (address, chipselect, write_n, writedata,
//              readdata)
//   out_port : registered output pins
//
// Register map (word address):
//   0 DATA   R/W  data_reg[7:0]
//   1 LEN    R/W  pulse_len[LEN_WIDTH-1:0]
//   2 PULSE  W    start pulse with mask writedata[7:0]; reads 0
//   3 STATUS R    bit0 = busy
//   4 SET    W    data_reg |= writedata[7:0]
//   5 CLEAR  W    data_reg &= ~writedata[7:0]
//   6,7      reserved, read 0
//
// Build option:
//   SOPC_PIO_WDATA_READBACK_EN - when defined, readdata returns the register
//   map above; when undefined, readdata is tied to 0 and no read path is
//   built.
// ---------------------------------------------------------------------------
module sopc_pio_wdata #(
    parameter logic [7:0] RESET_VALUE = 8'h00,
    parameter int         LEN_WIDTH   = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    sopc_pio_wdata_if.slave  bus,
    output logic [7:0]       out_port
);

    localparam logic [2:0] A_DATA   = 3'd0;
    localparam logic [2:0] A_LEN    = 3'd1;
    localparam logic [2:0] A_PULSE  = 3'd2;
    localparam logic [2:0] A_STATUS = 3'd3;
    localparam logic [2:0] A_SET    = 3'd4;
    localparam logic [2:0] A_CLEAR  = 3'd5;

    localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        PULSE = 1'b1
    } state_t;

    state_t               state, state_next;
    logic [7:0]           data_reg, data_next;
    logic [LEN_WIDTH-1:0] pulse_len, len_next;
    logic [7:0]           pulse_mask, mask_next;
    logic [LEN_WIDTH-1:0] cnt, cnt_next;
    logic [7:0]           out_next;
    logic                 wr;
    logic [7:0]           wbyte;

    // Only the low bits of writedata feed any register.
    logic unused_wdata;
    assign unused_wdata = ^bus.writedata[31:8];

    assign wr    = bus.chipselect && !bus.write_n;
    assign wbyte = bus.writedata[7:0];

    always_comb begin
        data_next  = data_reg;
        len_next   = pulse_len;
        state_next = state;
        mask_next  = pulse_mask;
        cnt_next   = cnt;

        if (wr) begin
            case (bus.address)
                A_DATA:  data_next = wbyte;
                A_LEN:   len_next  = bus.writedata[LEN_WIDTH-1:0];
                A_SET:   data_next = data_reg | wbyte;
                A_CLEAR: data_next = data_reg & ~wbyte;
                default: ;
            endcase
        end

        case (state)
            IDLE: begin
                // A zero length or zero mask would be a no-op pulse, so it
                // never leaves IDLE.
                if (wr && bus.address == A_PULSE &&
                    pulse_len != '0 && wbyte != 8'h00) begin
                    state_next = PULSE;
                    mask_next  = wbyte;
                    cnt_next   = pulse_len;
                end
            end
            PULSE: begin
                // Further PULSE writes are ignored here; the count only
                // runs down, so the pulse cannot be extended.
                if (cnt == LEN_ONE) begin
                    state_next = IDLE;
                    mask_next  = 8'h00;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt - LEN_ONE;
                end
            end
            default: state_next = IDLE;
        endcase

        // Output is built from next-state values so a write or pulse start
        // sampled at an edge shows on the pins right after that edge.
        out_next = data_next ^ ((state_next == PULSE) ? mask_next : 8'h00);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            data_reg   <= RESET_VALUE;
            pulse_len  <= LEN_ONE;
            pulse_mask <= 8'h00;
            cnt        <= '0;
            out_port   <= RESET_VALUE;
        end else begin
            state      <= state_next;
            data_reg   <= data_next;
            pulse_len  <= len_next;
            pulse_mask <= mask_next;
            cnt        <= cnt_next;
            out_port   <= out_next;
        end
    end

`ifdef SOPC_PIO_WDATA_READBACK_EN
    logic [31:0] rd_mux;

    // Reads use pre-edge register values, so reading a register in the same
    // cycle it is written returns the old contents.
    always_comb begin
        rd_mux = 32'h0;
        case (bus.address)
            A_DATA:   rd_mux = {24'h0, data_reg};
            A_LEN:    rd_mux = 32'(pulse_len);
            A_STATUS: rd_mux = {31'h0, state == PULSE};
            default:  rd_mux = 32'h0;
        endcase
    end

    // Sampled every cycle regardless of chipselect; no wait states.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.readdata <= 32'h0;
        end else begin
            bus.readdata <= rd_mux;
        end
    end
`else
    assign bus.readdata = 32'h0;
`endif

endmodule

// File: tb/tb_sopc_pio_wdata.sv
// ---------------------------------------------------------------------------
// tb_sopc_pio_wdata
//
// Directed bench for sopc_pio_wdata. Each stimulus cycle queues the
// out_port / readdata values expected after the next clock edge; a monitor
// pops and compares them after every edge (or on demand for the
// asynchronous reset check).
// ---------------------------------------------------------------------------
module tb_sopc_pio_wdata;

    localparam logic [7:0] RV = 8'hA5;

`ifdef SOPC_PIO_WDATA_READBACK_EN
    localparam logic [31:0] RB_MASK = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] RB_MASK = 32'h0000_0000;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] out_port;

    sopc_pio_wdata_if bus ();

    sopc_pio_wdata #(
        .RESET_VALUE(RV),
        .LEN_WIDTH  (16)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .out_port(out_port)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  out;
        logic [31:0] rd;
        int          idx;
    } exp_t;

    exp_t q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   step_no     = 0;
    event sample_ev;

    task automatic push(input logic [7:0] o, input logic [31:0] r);
        exp_t e;
        e.out = o;
        e.rd  = r & RB_MASK;
        e.idx = step_no;
        q.push_back(e);
        step_no++;
    endtask

    task automatic drive(input logic [2:0] a, input logic cs, input logic wn,
                         input logic [31:0] wd, input logic [7:0] o,
                         input logic [31:0] r);
        bus.address    = a;
        bus.chipselect = cs;
        bus.write_n    = wn;
        bus.writedata  = wd;
        push(o, r);
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] wd,
                      input logic [7:0] o, input logic [31:0] r);
        drive(a, 1'b1, 1'b0, wd, o, r);
    endtask

    task automatic rd(input logic [2:0] a, input logic [7:0] o,
                      input logic [31:0] r);
        drive(a, 1'b1, 1'b1, 32'h0, o, r);
    endtask

    task automatic idle(input logic [7:0] o);
        drive(3'd7, 1'b0, 1'b1, 32'h0, o, 32'h0);
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or sample_ev);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                vectors++;
                if (out_port !== e.out) begin
                    $display("FAIL out_port step %0d: got %h expected %h",
                             e.idx, out_port, e.out);
                    miscompares++;
                end
                vectors++;
                if (bus.readdata !== e.rd) begin
                    $display("FAIL readdata step %0d: got %h expected %h",
                             e.idx, bus.readdata, e.rd);
                    miscompares++;
                end
            end
        end
    end

    // Stimulus
    initial begin
        int guard;
        reset_n        = 1'b0;
        bus.address    = 3'd7;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = 32'h0;
        @(posedge clk);
        #2;

        // Reset state
        idle(RV);
        idle(RV);
        reset_n = 1'b1;
        rd(3'd1, RV, 32'd1);
        rd(3'd3, RV, 32'd0);
        rd(3'd0, RV, 32'h0000_00A5);

        // Set / clear, upper writedata bits must be ignored
        wr(3'd0, 32'h1234_560F, 8'h0F, 32'h0000_00A5);
        wr(3'd4, 32'hFFFF_FFF0, 8'hFF, 32'h0);
        wr(3'd5, 32'h0000_0003, 8'hFC, 32'h0);
        rd(3'd0, 8'hFC, 32'h0000_00FC);

        // Pulse LEN=5 mask 81, with an ignored retrigger mid-pulse
        wr(3'd1, 32'hABCD_0005, 8'hFC, 32'd1);
        wr(3'd0, 32'h0000_0000, 8'h00, 32'h0000_00FC);
        wr(3'd2, 32'h0000_0081, 8'h81, 32'h0);
        rd(3'd3, 8'h81, 32'd1);
        rd(3'd3, 8'h81, 32'd1);
        wr(3'd2, 32'h0000_0001, 8'h81, 32'h0);
        rd(3'd3, 8'h81, 32'd1);
        rd(3'd3, 8'h00, 32'd1);
        rd(3'd3, 8'h00, 32'd0);
        rd(3'd1, 8'h00, 32'd5);

        // LEN=0 makes PULSE a no-op
        wr(3'd1, 32'h0000_0000, 8'h00, 32'd5);
        wr(3'd2, 32'h0000_00FF, 8'h00, 32'h0);
        rd(3'd3, 8'h00, 32'd0);
        rd(3'd1, 8'h00, 32'd0);

        // DATA write during a pulse keeps the mask applied on the new base
        wr(3'd1, 32'h0000_0003, 8'h00, 32'd0);
        wr(3'd2, 32'h0000_0001, 8'h01, 32'h0);
        wr(3'd0, 32'h0000_0010, 8'h11, 32'h0);
        rd(3'd0, 8'h11, 32'h0000_0010);
        rd(3'd3, 8'h10, 32'd1);
        rd(3'd3, 8'h10, 32'd0);

        // Mask 0 is a no-op
        wr(3'd2, 32'h0000_0000, 8'h10, 32'h0);
        rd(3'd3, 8'h10, 32'd0);

        // Reset in the middle of a pulse
        wr(3'd1, 32'h0000_0004, 8'h10, 32'd3);
        wr(3'd2, 32'h0000_000F, 8'h1F, 32'h0);
        rd(3'd3, 8'h1F, 32'd1);
        reset_n = 1'b0;
        push(RV, 32'h0);
        ->sample_ev;
        idle(RV);
        reset_n = 1'b1;
        rd(3'd3, RV, 32'd0);
        rd(3'd1, RV, 32'd1);
        wr(3'd0, 32'h0000_0000, 8'h00, 32'h0000_00A5);
        wr(3'd1, 32'h0000_0002, 8'h00, 32'd1);
        wr(3'd2, 32'h0000_003C, 8'h3C, 32'h0);
        rd(3'd3, 8'h3C, 32'd1);
        rd(3'd3, 8'h00, 32'd1);
        rd(3'd3, 8'h00, 32'd0);

        // Reserved and STATUS writes are ignored
        wr(3'd6, 32'h0000_00FF, 8'h00, 32'h0);
        wr(3'd7, 32'h0000_00FF, 8'h00, 32'h0);
        wr(3'd3, 32'h0000_00FF, 8'h00, 32'h0);
        rd(3'd6, 8'h00, 32'h0);
        rd(3'd3, 8'h00, 32'd0);
        idle(8'h00);

        guard = 0;
        while (q.size() != 0 && guard < 10) begin
            @(posedge clk);
            #2;
            guard++;
        end
        vectors++;
        if (q.size() != 0) begin
            $display("FAIL drain: %0d entries unchecked, expected 0", q.size());
            miscompares++;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sopc_pio_wdata.md
# sopc_pio_wdata

Avalon-MM slave output PIO for the SOPC system. It is the write-side counterpart of the input PIO that samples `in_port` into `readdata`. The CPU drives an 8-bit `out_port` through a data register with atomic bit set/clear, and can request a self-timed inversion pulse of programmable length on selected bits. Register readback uses the same one-cycle registered `readdata` scheme as the system's input PIOs.

## Interface
- `RESET_VALUE`, 8'h00, value loaded into the data register at reset.
- `LEN_WIDTH`, 16, width of the pulse-length register and counter (2..16).
- `clk` input 1: system clock; every register is clocked on its rising edge.
- `reset_n` input 1: **one clock; reset is asynchronous and active-low**.
- `address` input 3: word address.
- `chipselect` input 1: slave select.
- `write_n` input 1: active-low write strobe; a write occurs when `chipselect && !write_n`.
- `writedata` input 32: write data; only the low bits are used per register.
- `readdata` output 32: registered read data.
- `out_port` output 8: registered output pins.

## Operation
- Register map:
  - 0 DATA (R/W): data_reg[7:0].
  - 1 LEN (R/W): pulse_len[LEN_WIDTH-1:0].
  - 2 PULSE (W): start a pulse with mask writedata[7:0]. Reads return 0.
  - 3 STATUS (R): bit0 = busy. Writes are ignored.
  - 4 SET (W): data_reg |= writedata[7:0].
  - 5 CLEAR (W): data_reg &= ~writedata[7:0].
  - 6, 7: reserved. Reads return 0; writes are ignored.
- FSM states: IDLE and PULSE.
  - IDLE → PULSE when PULSE is written with pulse_len != 0 and mask != 0. On that edge: pulse_mask <= mask, cnt <= pulse_len, busy = 1.
  - In PULSE, cnt decrements by 1 each cycle.
  - When cnt == 1, the next edge goes to IDLE, clears pulse_mask to 0, and clears busy.
  - A PULSE write while busy is ignored; the running pulse is neither retriggered nor extended.
  - A PULSE write with len == 0 or mask == 0 is ignored and the block stays in IDLE.
- Output: out_port <= data_reg_next ^ (busy_next ? pulse_mask_next : 0), registered.
- DATA, SET or CLEAR writes during a pulse update the base value immediately. Masked bits stay inverted relative to the new base.
- LEN writes during a pulse affect only later pulses.
- Reset values:
  - data_reg = RESET_VALUE
  - pulse_len = 1
  - pulse_mask = 0
  - cnt = 0
  - state = IDLE
  - out_port = RESET_VALUE
  - readdata = 0
- Reset asserted mid-pulse aborts it immediately (asynchronous). out_port returns to RESET_VALUE.
- Unused writedata bits are ignored. Readdata zero-extends all register values to 32 bits.

## Timing
- Write latency: a write sampled at edge N is visible on out_port after edge N.
- Pulse duration: masked bits are inverted for exactly pulse_len cycles, from edge N through edge N+pulse_len. busy reads 1 over the same window.
- Read latency: readdata <= mux(address) on every clock edge, regardless of chipselect. Valid one cycle after address is presented. There is no wait state.
- A same-cycle read of a register being written returns the old value. The new value is returned on the following cycle.
- Counter range: pulse_len up to 2^LEN_WIDTH−1. There is no wrap-around, because cnt stops at 1.

## Configuration
- `SOPC_PIO_WDATA_READBACK_EN`:
  - Defined: readdata returns the register map above.
  - Undefined: readdata is constant 0 and the read mux and readdata register are not built. Writes, out_port and the pulse behaviour are unchanged.

## Test plan
- Reset: hold reset_n low with RESET_VALUE=8'hA5 → out_port=8'hA5, readdata=0. After release, reading address 1 → 1 and address 3 → 0.
- Set/clear: write DATA=8'h0F, SET=8'hF0, CLEAR=8'h03 on consecutive cycles → out_port goes 0F, FF, FC. Reading address 0 → 32'h000000FC.
- Pulse: LEN=5, DATA=8'h00, PULSE=8'h81 → out_port=8'h81 for exactly 5 cycles, then 8'h00. STATUS bit0 is 1 over the same 5 cycles.
- Ignored pulses:
  - PULSE=8'h01 during an active LEN=5 pulse → no extension; the pulse still ends after 5 cycles.
  - LEN=0 then PULSE=8'hFF → no change on out_port, busy stays 0.
- Concurrent update: during a pulse with mask 8'h01, write DATA=8'h10 → out_port=8'h11 until the pulse ends, then 8'h10.
- Reset mid-pulse: assert reset_n at pulse cycle 2 → out_port=RESET_VALUE immediately and busy=0. A new pulse after release behaves normally. With `SOPC_PIO_WDATA_READBACK_EN` undefined, all reads return 0.
